// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding and requester indices for mem_port_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [1:0]            grant;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, grant
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata, grant
  );
endinterface

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - combinational 2-way pick; on a tie the requester other than last_grant wins
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any    = |req;
    winner = REQ_CPU;
    case (req)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_LDR;
      2'b11:   winner = ~last_grant;
      default: winner = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single-port memory arbiter (IDLE/ISSUE/RESP)
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default build gives requester 0 fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e            state;
  logic                  sel;
  logic                  sel_we;
  logic [1:0]            grant_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  pick_any;
  logic                  pick_idx;
  logic                  tie_ptr;

  arb_pick2 u_pick (
    .req        ({bus.req1, bus.req0}),
    .last_grant (tie_ptr),
    .any        (pick_any),
    .winner     (pick_idx)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Resetting to the loader makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= REQ_LDR;
    end else if (state == ST_RESP) begin
      last_grant <= sel;
    end
  end

  assign tie_ptr = last_grant;
`else
  assign tie_ptr = REQ_LDR;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= REQ_CPU;
      sel_we      <= 1'b0;
      grant_q     <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state       <= ST_ISSUE;
            sel         <= pick_idx;
            sel_we      <= pick_idx ? bus.we1 : bus.we0;
            grant_q     <= idx_to_onehot(pick_idx);
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_idx ? bus.we1 : bus.we0;
            mem_addr_q  <= pick_idx ? bus.addr1 : bus.addr0;
            mem_wdata_q <= pick_idx ? bus.wdata1 : bus.wdata0;
          end
        end
        ST_ISSUE: begin
          state       <= ST_RESP;
          grant_q     <= 2'b00;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          ack0_q      <= (sel == REQ_CPU);
          ack1_q      <= (sel == REQ_LDR);
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (!sel_we) begin
            if (sel == REQ_LDR) rdata1_q <= bus.mem_rdata;
            else                rdata0_q <= bus.mem_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;

  // Memory data arrives in the ack cycle itself, so it is forwarded then and held afterwards.
  assign bus.rdata0 = (ack0_q && !sel_we) ? bus.mem_rdata : rdata0_q;
  assign bus.rdata1 = (ack1_q && !sel_we) ? bus.mem_rdata : rdata1_q;

endmodule
